reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 64 ++++++
 tb/tb_reg_scoreboard.sv | 138 +++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register scoreboard for long-latency writes with RAW/WAW/full stall and drain FSM.
// Define SCOREBOARD_BYPASS_EN to let a same-cycle writeback lift the stall it resolves.
module reg_scoreboard #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs_decode,
  input  logic [4:0]  rt_decode,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        drain_req,
  output logic        stall_decode,
  output logic [31:0] pending_mask,
  output logic [2:0]  pending_count,
  output logic        drained,
  output logic        wb_err
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state;
  logic wb_hit, accept, raw, waw, full;
  logic byp_rs, byp_rt, byp_rd, byp_full;
  logic [31:0] set_vec, clr_vec;
  assign wb_hit = wb_valid & (wb_rd != 5'd0) & pending_mask[wb_rd];
`ifdef SCOREBOARD_BYPASS_EN
  assign byp_rs   = wb_valid & (wb_rd == rs_decode);
  assign byp_rt   = wb_valid & (wb_rd == rt_decode);
  assign byp_rd   = wb_valid & (wb_rd == issue_rd);
  assign byp_full = wb_hit;
`else
  assign byp_rs   = 1'b0;
  assign byp_rt   = 1'b0;
  assign byp_rd   = 1'b0;
  assign byp_full = 1'b0;
`endif
  assign raw = ((rs_decode != 5'd0) & pending_mask[rs_decode] & ~byp_rs) |
               ((rt_decode != 5'd0) & pending_mask[rt_decode] & ~byp_rt);
  assign waw = issue_long & (issue_rd != 5'd0) & pending_mask[issue_rd] & ~byp_rd;
  assign full = issue_long & (pending_count == 3'(MAX_PENDING)) & ~byp_full;
  assign stall_decode = raw | waw | full | (state == DRAIN);
  assign accept = issue_valid & issue_long & ~stall_decode & (issue_rd != 5'd0);
  assign set_vec = 32'(accept) << issue_rd;
  assign clr_vec = 32'(wb_hit) << wb_rd;
  assign drained = (state == DRAIN) & (pending_count == 3'd0);
  always_comb begin
    pending_count = 3'd0;
    for (int i = 1; i < 32; i++) pending_count = pending_count + 3'(pending_mask[i]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      pending_mask <= '0;
      wb_err       <= 1'b0;
    end else begin
      pending_mask <= ((pending_mask & ~clr_vec) | set_vec) & ~32'd1;
      wb_err       <= wb_err | (wb_valid & ~wb_hit);
      state        <= (state == RUN) ? (drain_req ? DRAIN : RUN)
                    : ((pending_count == 3'd0 && !drain_req) ? RUN : DRAIN);
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed self-checking bench for reg_scoreboard (MAX_PENDING=4).
module tb_reg_scoreboard;
  logic clk = 1'b0, rst = 1'b1;
  logic issue_valid = 0, issue_long = 0, wb_valid = 0, drain_req = 0;
  logic [4:0] issue_rd = 0, rs_decode = 0, rt_decode = 0, wb_rd = 0;
  logic stall_decode, drained, wb_err;
  logic [31:0] pending_mask;
  logic [2:0] pending_count;
  int checks = 0, failures = 0;
`ifdef SCOREBOARD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  reg_scoreboard #(.MAX_PENDING(4)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd(issue_rd), .rs_decode(rs_decode), .rt_decode(rt_decode),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .drain_req(drain_req),
    .stall_decode(stall_decode), .pending_mask(pending_mask),
    .pending_count(pending_count), .drained(drained), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_long = 0; issue_rd = 0;
    rs_decode = 0; rt_decode = 0; wb_valid = 0; wb_rd = 0; drain_req = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    issue_valid = 1; issue_long = 1; issue_rd = rd;
  endtask

  task automatic wb(input logic [4:0] rd);
    idle();
    wb_valid = 1; wb_rd = rd;
  endtask

  initial begin
    repeat (2) cyc();
    #1 check("rst_stall", stall_decode, 0);
    rst = 0;
    cyc();
    check("rst_mask", pending_mask, 0);
    check("rst_count", pending_count, 0);
    check("rst_err", wb_err, 0);
    check("rst_drained", drained, 0);
    check("rst_stall_after", stall_decode, 0);

    // RAW on rs/rt, resolved by writeback
    issue(5); #1 check("raw_issue_nostall", stall_decode, 0);
    cyc(); idle(); rs_decode = 5; #1;
    check("raw_mask", pending_mask, 32'h20);
    check("raw_count", pending_count, 1);
    check("raw_stall_rs", stall_decode, 1);
    rs_decode = 0; rt_decode = 5; #1 check("raw_stall_rt", stall_decode, 1);
    cyc(); check("raw_stall_hold", stall_decode, 1);
    rt_decode = 0; rs_decode = 5; wb_valid = 1; wb_rd = 5; #1;
    check("raw_bypass", stall_decode, {31'd0, ~BYP});
    cyc(); wb_valid = 0; #1;
    check("raw_cleared", pending_mask, 0);
    check("raw_stall_drop", stall_decode, 0);

    // full stall at MAX_PENDING
    for (int i = 1; i <= 4; i++) begin issue(5'(i)); cyc(); end
    issue(6); #1;
    check("full_stall", stall_decode, 1);
    check("full_count", pending_count, 4);
    check("full_mask", pending_mask, 32'h1E);
    issue(6); issue_rd = 4; #1 check("waw_stall", stall_decode, 1);
    issue_rd = 6;
    cyc(); check("full_no_accept", pending_mask, 32'h1E);
    wb_valid = 1; wb_rd = 2; #1;
    check("full_bypass", stall_decode, {31'd0, ~BYP});
    cyc(); wb_valid = 0; wb_rd = 0;
    cyc();
    check("full_after_wb", pending_mask, 32'h5A);
    check("full_count_after", pending_count, 4);
    wb(1); cyc(); wb(3); cyc(); wb(4); cyc(); wb(6); cyc(); idle(); #1;
    check("full_drain_mask", pending_mask, 0);
    check("full_err", wb_err, 0);

    // rd = 0 is never tracked
    issue(0); #1 check("rd0_stall", stall_decode, 0);
    cyc(); idle(); #1;
    check("rd0_mask", pending_mask, 0);
    check("rd0_count", pending_count, 0);

    // drain FSM
    issue(8); cyc(); issue(9); cyc(); idle(); drain_req = 1; #1;
    check("drain_pre_stall", stall_decode, 0);
    cyc(); drain_req = 0; #1;
    check("drain_stall", stall_decode, 1);
    check("drain_not_drained", drained, 0);
    issue(10); wb_valid = 1; wb_rd = 8;
    cyc(); check("drain_no_issue", pending_mask, 32'h200);
    wb(9); cyc(); idle(); #1;
    check("drain_drained", drained, 1);
    check("drain_stall_hold", stall_decode, 1);
    cyc();
    check("drain_exit_drained", drained, 0);
    check("drain_exit_stall", stall_decode, 0);

    // stray writeback is sticky
    wb(9); cyc(); idle(); #1;
    check("err_set", wb_err, 1);
    check("err_count", pending_count, 0);
    repeat (3) cyc();
    check("err_hold", wb_err, 1);

    // async reset mid-operation
    issue(12); cyc(); idle(); #1;
    check("mid_mask", pending_mask, 32'h1000);
    rst = 1; #1;
    check("mid_rst_mask", pending_mask, 0);
    check("mid_rst_err", wb_err, 0);
    cyc(); rst = 0; wb(12); cyc(); idle(); #1;
    check("mid_rst_wb_err", wb_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
